// File: rtl/hazard_ctrl_if.sv
// Hazard control bundle: pipeline-side hazard/memory inputs, per-stage
// enable/flush strobes, watchdog error and performance counters.
interface hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             Need_Stall;
  logic             IDex__Branch_Taken;
  logic             EXmem__MemEnable;
  logic             Mem_Ready;
  logic             Cnt_Clr;
  logic             PC_En;
  logic             IFid_En;
  logic             IFid_Flush;
  logic             IDex_En;
  logic             IDex_Flush;
  logic             EXmem_En;
  logic             MEMwb_En;
  logic             MEMwb_Flush;
  logic             Mem_Timeout;
  logic [CNT_W-1:0] Stall_Cnt;
  logic [CNT_W-1:0] Flush_Cnt;
  logic [CNT_W-1:0] Wait_Cnt;

  // hazard controller side
  modport slave (
    input  Need_Stall, IDex__Branch_Taken, EXmem__MemEnable, Mem_Ready, Cnt_Clr,
    output PC_En, IFid_En, IFid_Flush, IDex_En, IDex_Flush, EXmem_En,
           MEMwb_En, MEMwb_Flush, Mem_Timeout, Stall_Cnt, Flush_Cnt, Wait_Cnt
  );

  // pipeline side
  modport master (
    output Need_Stall, IDex__Branch_Taken, EXmem__MemEnable, Mem_Ready, Cnt_Clr,
    input  PC_En, IFid_En, IFid_Flush, IDex_En, IDex_Flush, EXmem_En,
           MEMwb_En, MEMwb_Flush, Mem_Timeout, Stall_Cnt, Flush_Cnt, Wait_Cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: prioritised freeze/redirect/load-use strobes,
// memory-wait FSM with a timeout watchdog, saturating event counters.
module hazard_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic          clk,
  input  logic          rst,
  hazard_ctrl_if.slave  hz
);
  // timer never needs to exceed TIMEOUT-1
  localparam int TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {RUN, MWAIT, ERROR} state_t;

  state_t           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  logic mem_wait, freeze, redirect, load_use;

  // classify the cycle; higher-priority events mask lower ones
  always_comb begin
    mem_wait = hz.EXmem__MemEnable && !hz.Mem_Ready;
    freeze   = mem_wait || (state_q == ERROR);
    redirect = !freeze && hz.IDex__Branch_Taken;
    load_use = !freeze && !redirect && hz.Need_Stall;
  end

  // per-stage strobes; reset fills every stage with bubbles, PC held
  always_comb begin
    hz.PC_En       = 1'b1;
    hz.IFid_En     = 1'b1;
    hz.IFid_Flush  = 1'b0;
    hz.IDex_En     = 1'b1;
    hz.IDex_Flush  = 1'b0;
    hz.EXmem_En    = 1'b1;
    hz.MEMwb_En    = 1'b1;
    hz.MEMwb_Flush = 1'b0;
    if (rst) begin
      hz.PC_En       = 1'b0;
      hz.IFid_Flush  = 1'b1;
      hz.IDex_Flush  = 1'b1;
      hz.MEMwb_Flush = 1'b1;
    end else if (freeze) begin
      // WB takes a bubble so the stalled MEM result is not written twice
      hz.PC_En       = 1'b0;
      hz.IFid_En     = 1'b0;
      hz.IDex_En     = 1'b0;
      hz.EXmem_En    = 1'b0;
      hz.MEMwb_Flush = 1'b1;
    end else if (redirect) begin
      hz.IFid_Flush  = 1'b1;
      hz.IDex_Flush  = 1'b1;
    end else if (load_use) begin
      hz.PC_En       = 1'b0;
      hz.IFid_En     = 1'b0;
      hz.IDex_Flush  = 1'b1;
    end
  end

  // memory-wait FSM and watchdog timer next state
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    unique case (state_q)
      RUN: begin
        if (mem_wait) begin
          state_d = MWAIT;
          timer_d = TMR_W'(1);
        end
      end
      MWAIT: begin
        if (!mem_wait) begin
          state_d = RUN;
          timer_d = '0;
        end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
          state_d = ERROR;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      ERROR:   state_d = ERROR;
      default: state_d = RUN;
    endcase
  end

  // saturating counters; clear wins over increment
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    if (hz.Cnt_Clr) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
      wait_cnt_d  = '0;
    end else begin
      if (load_use && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (redirect && flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_W'(1);
      if (freeze   && wait_cnt_q  != '1) wait_cnt_d  = wait_cnt_q  + CNT_W'(1);
    end
  end

  // state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      timer_q     <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      wait_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  // sticky error is simply "FSM parked in ERROR"
  always_comb begin
    hz.Mem_Timeout = (state_q == ERROR);
    hz.Stall_Cnt   = stall_cnt_q;
    hz.Flush_Cnt   = flush_cnt_q;
    hz.Wait_Cnt    = wait_cnt_q;
  end
endmodule
